// File: rtl/id_ex_decode.sv
// id_ex_decode: decodes the decode-stage instruction and holds the result in the ID/EX register
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   InstrD, PCD, ValidD     decode-stage instruction, its PC, and its valid flag
//   StallE, FlushE          hazard unit: hold the ID/EX register / load a bubble (flush wins)
//   ALUctrlE, ImmExtE, PCE  ALU code (000 add 001 sub 010 and 011 or 100 xor 110 sll 111 srl), immediate, PC
//   Rs1E, Rs2E, RdE         register indices
//   ALUSrcE, RegWriteE, MemWriteE, BranchE, JumpE, ResultSrcE, ValidE  execute-stage controls
//   IllegalE, IllegalSticky illegal-instruction slot flag and sticky latch
// Option macro ILLEGAL_DETECT_EN: an illegal instruction becomes a flagged bubble and sets the sticky flag.
// Without it, an illegal instruction passes through as a valid no-op and both illegal outputs are 0.
module id_ex_decode #(
  parameter int DATA_WIDTH = 32,
  parameter int PC_WIDTH   = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [31:0]           InstrD,
  input  logic [PC_WIDTH-1:0]   PCD,
  input  logic                  ValidD,
  input  logic                  StallE,
  input  logic                  FlushE,
  output logic [2:0]            ALUctrlE,
  output logic [DATA_WIDTH-1:0] ImmExtE,
  output logic [PC_WIDTH-1:0]   PCE,
  output logic [4:0]            Rs1E,
  output logic [4:0]            Rs2E,
  output logic [4:0]            RdE,
  output logic                  ALUSrcE,
  output logic                  RegWriteE,
  output logic                  MemWriteE,
  output logic                  BranchE,
  output logic                  JumpE,
  output logic [1:0]            ResultSrcE,
  output logic                  ValidE,
  output logic                  IllegalE,
  output logic                  IllegalSticky
);
  typedef struct packed {
    logic [2:0]            alu;
    logic [DATA_WIDTH-1:0] imm;
    logic [PC_WIDTH-1:0]   pc;
    logic [4:0]            rs1;
    logic [4:0]            rs2;
    logic [4:0]            rd;
    logic                  alusrc;
    logic                  regw;
    logic                  memw;
    logic                  br;
    logic                  jmp;
    logic [1:0]            res;
    logic                  valid;
    logic                  ill;
  } idex_t;

  idex_t       w_d, r_q;
  logic        w_ill, w_abad;
  logic [6:0]  w_op, w_f7;
  logic [2:0]  w_f3, w_amap;
  logic [31:0] w_imm_i, w_imm_s, w_imm_b, w_imm_u, w_imm_j;

  assign w_op    = InstrD[6:0];
  assign w_f3    = InstrD[14:12];
  assign w_f7    = InstrD[31:25];
  assign w_imm_i = {{20{InstrD[31]}}, InstrD[31:20]};
  assign w_imm_s = {{20{InstrD[31]}}, InstrD[31:25], InstrD[11:7]};
  assign w_imm_b = {{19{InstrD[31]}}, InstrD[31], InstrD[7], InstrD[30:25], InstrD[11:8], 1'b0};
  assign w_imm_u = {InstrD[31:12], 12'b0};
  assign w_imm_j = {{11{InstrD[31]}}, InstrD[31], InstrD[19:12], InstrD[20], InstrD[30:21], 1'b0};

  // funct3 to ALU code shared by R-type and I-type ALU ops; slt/sltu have no code
  assign w_amap = w_f3 == 3'b111 ? 3'b010 :
                  w_f3 == 3'b110 ? 3'b011 :
                  w_f3 == 3'b100 ? 3'b100 :
                  w_f3 == 3'b001 ? 3'b110 :
                  w_f3 == 3'b101 ? 3'b111 : 3'b000;
  assign w_abad = w_f3[2:1] == 2'b01;

  always_comb begin
    w_d       = '0;
    w_ill     = 1'b0;
    w_d.pc    = PCD;
    w_d.rs1   = InstrD[19:15];
    w_d.rs2   = InstrD[24:20];
    w_d.rd    = InstrD[11:7];
    w_d.valid = 1'b1;
    case (w_op)
      7'b0110011: begin
        w_d.alu  = (w_f3 == 3'b000 && w_f7 == 7'h20) ? 3'b001 : w_amap;
        w_d.regw = 1'b1;
        w_ill    = w_abad || !(w_f7 == 7'h00 || (w_f3 == 3'b000 && w_f7 == 7'h20));
      end
      7'b0010011: begin
        w_d.alu    = w_amap;
        w_d.imm    = DATA_WIDTH'($signed(w_imm_i));
        w_d.alusrc = 1'b1;
        w_d.regw   = 1'b1;
        w_ill      = w_abad || (w_f3[1:0] == 2'b01 && w_f7 != 7'h00);
      end
      7'b0000011: begin
        w_d.imm    = DATA_WIDTH'($signed(w_imm_i));
        w_d.alusrc = 1'b1;
        w_d.res    = 2'b01;
        w_d.regw   = 1'b1;
        w_ill      = w_f3 != 3'b010;
      end
      7'b0100011: begin
        w_d.imm    = DATA_WIDTH'($signed(w_imm_s));
        w_d.alusrc = 1'b1;
        w_d.memw   = 1'b1;
        w_ill      = w_f3 != 3'b010;
      end
      7'b1100011: begin
        w_d.alu = 3'b001;
        w_d.imm = DATA_WIDTH'($signed(w_imm_b));
        w_d.br  = 1'b1;
        w_ill   = w_f3[2:1] != 2'b00;
      end
      7'b0110111: begin
        w_d.rs1    = 5'd0;
        w_d.imm    = DATA_WIDTH'($signed(w_imm_u));
        w_d.alusrc = 1'b1;
        w_d.regw   = 1'b1;
      end
      7'b1101111: begin
        w_d.imm  = DATA_WIDTH'($signed(w_imm_j));
        w_d.jmp  = 1'b1;
        w_d.res  = 2'b10;
        w_d.regw = 1'b1;
      end
      default: w_ill = 1'b1;
    endcase
    if (w_d.rd == 5'd0) w_d.regw = 1'b0;
`ifdef ILLEGAL_DETECT_EN
    if (w_ill) begin
      w_d     = '0;
      w_d.ill = 1'b1;
    end
`else
    if (w_ill) {w_d.alu, w_d.alusrc, w_d.regw, w_d.memw, w_d.br, w_d.jmp, w_d.res} = '0;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_q <= '0;
    else if (FlushE) r_q <= '0;
    else if (!StallE) r_q <= ValidD ? w_d : '0;
  end

`ifdef ILLEGAL_DETECT_EN
  logic r_sticky;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_sticky <= 1'b0;
    else if (!FlushE && !StallE && ValidD && w_ill) r_sticky <= 1'b1;
  end
  assign IllegalSticky = r_sticky;
`else
  assign IllegalSticky = 1'b0;
`endif

  assign {ALUctrlE, ImmExtE, PCE, Rs1E, Rs2E, RdE, ALUSrcE, RegWriteE, MemWriteE,
          BranchE, JumpE, ResultSrcE, ValidE, IllegalE} = r_q;
endmodule

// File: tb/tb_id_ex_decode.sv
// tb_id_ex_decode: table-driven and sequence checks of the ID/EX decode register
module tb_id_ex_decode;
  typedef struct packed {
    logic [2:0]  alu;
    logic [31:0] imm;
    logic [31:0] pc;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [4:0]  ctl;
    logic [1:0]  res;
    logic        valid;
    logic        ill;
  } outs_t;
  typedef struct {
    logic [31:0] instr;
    logic        vld;
    outs_t       exp;
  } vec_t;

  logic        clk, rst_n, ValidD, StallE, FlushE;
  logic [31:0] InstrD, PCD;
  logic [2:0]  ALUctrlE;
  logic [31:0] ImmExtE, PCE;
  logic [4:0]  Rs1E, Rs2E, RdE;
  logic        ALUSrcE, RegWriteE, MemWriteE, BranchE, JumpE, ValidE, IllegalE, IllegalSticky;
  logic [1:0]  ResultSrcE;
  outs_t       got;
  int          n_chk = 0, n_fail = 0;
  vec_t        vecs[12];
  logic        sticky_exp;

  id_ex_decode dut (
    .clk(clk), .rst_n(rst_n), .InstrD(InstrD), .PCD(PCD), .ValidD(ValidD),
    .StallE(StallE), .FlushE(FlushE), .ALUctrlE(ALUctrlE), .ImmExtE(ImmExtE),
    .PCE(PCE), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE), .ALUSrcE(ALUSrcE),
    .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .BranchE(BranchE), .JumpE(JumpE),
    .ResultSrcE(ResultSrcE), .ValidE(ValidE), .IllegalE(IllegalE),
    .IllegalSticky(IllegalSticky)
  );

  assign got = {ALUctrlE, ImmExtE, PCE, Rs1E, Rs2E, RdE,
                ALUSrcE, RegWriteE, MemWriteE, BranchE, JumpE, ResultSrcE, ValidE, IllegalE};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ctl bits: {ALUSrc, RegWrite, MemWrite, Branch, Jump}
  function automatic outs_t mk(input logic [2:0] a, input logic [31:0] imm, input logic [31:0] pc,
                               input logic [4:0] s1, input logic [4:0] s2, input logic [4:0] d,
                               input logic [4:0] ctl, input logic [1:0] res, input logic v,
                               input logic il);
    return {a, imm, pc, s1, s2, d, ctl, res, v, il};
  endfunction

  task automatic chk(input string nm, input outs_t g, input outs_t e);
    n_chk++;
    if (g !== e) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, g, e);
    end
  endtask

  task automatic chk1(input string nm, input logic g, input logic e);
    n_chk++;
    if (g !== e) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", nm, g, e);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    vecs[0]  = '{32'hFFD08293, 1'b1, mk(3'd0, 32'hFFFFFFFD, 32'h1000, 5'd1, 5'd29, 5'd5, 5'b11000, 2'd0, 1'b1, 1'b0)};
    vecs[1]  = '{32'h402081B3, 1'b1, mk(3'd1, 32'h0, 32'h1004, 5'd1, 5'd2, 5'd3, 5'b01000, 2'd0, 1'b1, 1'b0)};
    vecs[2]  = '{32'h00208463, 1'b1, mk(3'd1, 32'h8, 32'h1008, 5'd1, 5'd2, 5'd8, 5'b00010, 2'd0, 1'b1, 1'b0)};
    vecs[3]  = '{32'h00412303, 1'b1, mk(3'd0, 32'h4, 32'h100C, 5'd2, 5'd4, 5'd6, 5'b11000, 2'd1, 1'b1, 1'b0)};
    vecs[4]  = '{32'h0071A423, 1'b1, mk(3'd0, 32'h8, 32'h1010, 5'd3, 5'd7, 5'd8, 5'b10100, 2'd0, 1'b1, 1'b0)};
    vecs[5]  = '{32'h12345537, 1'b1, mk(3'd0, 32'h12345000, 32'h1014, 5'd0, 5'd3, 5'd10, 5'b11000, 2'd0, 1'b1, 1'b0)};
    vecs[6]  = '{32'hFFDFF0EF, 1'b1, mk(3'd0, 32'hFFFFFFFC, 32'h1018, 5'd31, 5'd29, 5'd1, 5'b01001, 2'd2, 1'b1, 1'b0)};
    vecs[7]  = '{32'h00208033, 1'b1, mk(3'd0, 32'h0, 32'h101C, 5'd1, 5'd2, 5'd0, 5'b00000, 2'd0, 1'b1, 1'b0)};
    vecs[8]  = '{32'h0062F233, 1'b1, mk(3'd2, 32'h0, 32'h1020, 5'd5, 5'd6, 5'd4, 5'b01000, 2'd0, 1'b1, 1'b0)};
    vecs[9]  = '{32'h0021D193, 1'b1, mk(3'd7, 32'h2, 32'h1024, 5'd3, 5'd2, 5'd3, 5'b11000, 2'd0, 1'b1, 1'b0)};
    vecs[10] = '{32'hFFD08293, 1'b0, '0};
`ifdef ILLEGAL_DETECT_EN
    vecs[11] = '{32'h4020D0B3, 1'b1, mk(3'd0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0, 5'b00000, 2'd0, 1'b0, 1'b1)};
    sticky_exp = 1'b1;
`else
    vecs[11] = '{32'h4020D0B3, 1'b1, mk(3'd0, 32'h0, 32'h102C, 5'd1, 5'd2, 5'd1, 5'b00000, 2'd0, 1'b1, 1'b0)};
    sticky_exp = 1'b0;
`endif
    rst_n = 1'b0; ValidD = 1'b0; StallE = 1'b0; FlushE = 1'b0; InstrD = '0; PCD = '0;
    repeat (2) step();
    chk("reset", got, '0);
    chk1("reset_sticky", IllegalSticky, 1'b0);
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      InstrD = vecs[i].instr;
      ValidD = vecs[i].vld;
      PCD    = 32'h1000 + 32'(i * 4);
      step();
      chk($sformatf("vec%0d", i), got, vecs[i].exp);
    end
    chk1("sticky_after_illegal", IllegalSticky, sticky_exp);
    // load held through a 3-cycle stall while the decode input keeps changing
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    InstrD = 32'h00412303; PCD = 32'h2000; ValidD = 1'b1;
    step();
    chk("stall_load", got, mk(3'd0, 32'h4, 32'h2000, 5'd2, 5'd4, 5'd6, 5'b11000, 2'd1, 1'b1, 1'b0));
    StallE = 1'b1;
    for (int i = 0; i < 3; i++) begin
      InstrD = 32'h402081B3 + 32'(i);
      PCD    = 32'h2004 + 32'(i * 4);
      step();
      chk($sformatf("stall_hold%0d", i), got, mk(3'd0, 32'h4, 32'h2000, 5'd2, 5'd4, 5'd6, 5'b11000, 2'd1, 1'b1, 1'b0));
    end
    FlushE = 1'b1;
    step();
    chk("flush_over_stall", got, '0);
    FlushE = 1'b0; StallE = 1'b0;
    // illegal then a valid add: sticky must survive, and survive a flush
    InstrD = 32'h4020D0B3; PCD = 32'h3000;
    step();
    InstrD = 32'h002081B3; PCD = 32'h3004;
    step();
    chk("add_after_illegal", got, mk(3'd0, 32'h0, 32'h3004, 5'd1, 5'd2, 5'd3, 5'b01000, 2'd0, 1'b1, 1'b0));
    chk1("sticky_after_add", IllegalSticky, sticky_exp);
    FlushE = 1'b1;
    step();
    chk1("sticky_after_flush", IllegalSticky, sticky_exp);
    FlushE = 1'b0;
    // asynchronous reset while stalled, checked before the next rising edge
    InstrD = 32'hFFD08293; PCD = 32'h4000;
    step();
    StallE = 1'b1;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("async_reset", got, '0);
    chk1("async_reset_sticky", IllegalSticky, 1'b0);
    step();
    rst_n = 1'b1; StallE = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
